aes_dec_key_unit: RTL and testbench

Round-key engine for the iterative AES-128 decryption datapath. It expands a 128-bit cipher key forward to the round-10 key, then steps backward one round key per request, supplying each decryption round key in order. It also provides a combinational InvMixColumns stage over a full 128-bit state, used by the round datapath.

---
 rtl/aes_dec_key_if.sv | 23 ++
 rtl/aes_dec_key_unit.sv | 141 ++++++++++++++
 tb/tb_aes_dec_key_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_key_if.sv
// Handshake and data bundle for the AES-128 decryption round-key unit.
interface aes_dec_key_if;
   logic         start;
   logic [127:0] key_in;
   logic         next;
   logic         busy;
   logic         key_ready;
   logic [3:0]   round_idx;
   logic [127:0] round_key;
   logic [7:0]   rcon;
   logic [127:0] mix_in;
   logic [127:0] mix_out;

   modport master (
      output start, key_in, next, mix_in,
      input  busy, key_ready, round_idx, round_key, rcon, mix_out
   );

   modport slave (
      input  start, key_in, next, mix_in,
      output busy, key_ready, round_idx, round_key, rcon, mix_out
   );
endinterface

// File: rtl/aes_dec_key_unit.sv
// AES-128 decryption key engine: forward-expands to the round-10 key, then walks back one
// round key per request. Also hosts a combinational InvMixColumns over a full state.
module aes_dec_key_unit (
   input logic         clk,
   input logic         reset,
   aes_dec_key_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

   // Byte 0x00 sits in the top byte, so entry b lives at bit offset 8*(255-b).
   localparam logic [2047:0] SboxTbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SboxTbl[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      logic [31:0] r;
      r = {w[23:0], w[31:24]};
      return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   state_e       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   idx_q, idx_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] fwd_key, inv_key;
   logic         step_back;

   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.start) begin
         state_d = StExpand;
      end else if (state_q == StExpand && idx_q == 4'd9) begin
         state_d = StReady;
      end
   end

   always_comb begin
      bus.busy      = (state_q == StExpand);
      bus.key_ready = (state_q == StReady);
   end

   always_comb begin
      logic [31:0] t, f0, f1, f2, i3, i2, i1;
      t  = sub_rot(key_q[31:0]) ^ {rcon_q, 24'h0};
      f0 = key_q[127:96] ^ t;
      f1 = key_q[95:64] ^ f0;
      f2 = key_q[63:32] ^ f1;
      fwd_key = {f0, f1, f2, key_q[31:0] ^ f2};
      // Inverse step rebuilds w3..w1 first; w0 then needs the recovered w3.
      i3 = key_q[31:0] ^ key_q[63:32];
      i2 = key_q[63:32] ^ key_q[95:64];
      i1 = key_q[95:64] ^ key_q[127:96];
      inv_key = {key_q[127:96] ^ sub_rot(i3) ^ {rcon_q, 24'h0}, i1, i2, i3};
   end

   assign step_back = (state_q == StReady) && bus.next && (idx_q != 4'd0);

   always_comb begin
      key_d  = key_q;
      idx_d  = idx_q;
      rcon_d = rcon_q;
      if (bus.start) begin
         key_d  = bus.key_in;
         idx_d  = 4'd0;
         rcon_d = 8'h01;
      end else if (state_q == StExpand) begin
         key_d  = fwd_key;
         idx_d  = idx_q + 4'd1;
         rcon_d = (idx_q == 4'd9) ? 8'h36 : xtime(rcon_q);
      end else if (step_back) begin
         key_d  = inv_key;
         idx_d  = idx_q - 4'd1;
         rcon_d = inv_xtime(rcon_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         key_q  <= '0;
         idx_q  <= '0;
         rcon_q <= '0;
      end else begin
         key_q  <= key_d;
         idx_q  <= idx_d;
         rcon_q <= rcon_d;
      end
   end

   assign bus.round_key = key_q;
   assign bus.round_idx = idx_q;
   assign bus.rcon      = rcon_q;

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign bus.mix_out[32*c+31 -: 32] = inv_mix_col(bus.mix_in[32*c+31 -: 32]);
   end
endmodule

// File: tb/tb_aes_dec_key_unit.sv
// Self-checking bench for aes_dec_key_unit against a FIPS-197 style key schedule model.
module tb_aes_dec_key_unit;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   aes_dec_key_if bus ();

   aes_dec_key_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]   sb   [256];
   logic [7:0]   rc_m [10];
   logic [127:0] rk_m [11];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box from first principles: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      rc_m[0] = 8'h01;
      for (int j = 1; j < 10; j++) rc_m[j] = gmul(rc_m[j-1], 8'h02);
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic build_sched(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rc_m[i/4-1], 24'h0};
         w[i] = w[i-4] ^ t;
      end
      for (int n = 0; n < 11; n++) rk_m[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endtask

   function automatic logic [127:0] mix_model(input logic [127:0] s);
      logic [7:0]   coef [4];
      logic [127:0] r = '0;
      logic [7:0]   o;
      coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            o = 8'h00;
            for (int k = 0; k < 4; k++)
               o = o ^ gmul(coef[(k - row) & 3], s[32*c + 31 - 8*k -: 8]);
            r[32*c + 31 - 8*row -: 8] = o;
         end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.next = 1'b1;
      bus.key_in = '0;
      bus.mix_in = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      bus.next = 1'b0;
      checks++;
      if (bus.round_key !== '0 || bus.round_idx !== 4'd0 || bus.rcon !== 8'h00 ||
          bus.busy !== 1'b0 || bus.key_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset: key=%h idx=%0d rcon=%h busy=%b rdy=%b, want all zero",
                  bus.round_key, bus.round_idx, bus.rcon, bus.busy, bus.key_ready);
      end
   endtask

   // Full load/expand/walk for one key; fips adds the published intermediate keys.
   task automatic test_expand_walk(input logic [127:0] key, input bit fips);
      logic [7:0] exp_rc;
      build_sched(key);
      bus.key_in = key;
      bus.start = 1'b1;
      bus.next = 1'b0;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.round_key !== key || bus.round_idx !== 4'd0 || bus.busy !== 1'b1 ||
          bus.rcon !== 8'h01) begin
         errors++;
         $display("FAIL load: key=%h idx=%0d busy=%b rcon=%h, want key=%h idx=0 busy=1 rcon=01",
                  bus.round_key, bus.round_idx, bus.busy, bus.rcon, key);
      end
      for (int n = 1; n <= 10; n++) begin
         bus.next = 1'($urandom_range(0, 1));
         tick();
         exp_rc = (n < 10) ? rc_m[n] : 8'h36;
         checks++;
         if (bus.round_key !== rk_m[n] || bus.round_idx !== 4'(n) || bus.rcon !== exp_rc ||
             bus.busy !== (n < 10) || bus.key_ready !== (n == 10)) begin
            errors++;
            $display("FAIL expand[%0d]: key=%h idx=%0d rcon=%h busy=%b rdy=%b, want key=%h rcon=%h",
                     n, bus.round_key, bus.round_idx, bus.rcon, bus.busy, bus.key_ready,
                     rk_m[n], exp_rc);
         end
         if (fips && (n == 1 || n == 10)) begin
            checks++;
            if (bus.round_key !== (n == 1 ? 128'ha0fafe1788542cb123a339392a6c7605
                                          : 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) begin
               errors++;
               $display("FAIL fips_round%0d: got %h", n, bus.round_key);
            end
         end
      end
      bus.next = 1'b1;
      for (int i = 9; i >= 0; i--) begin
         tick();
         exp_rc = (i == 0) ? 8'h8d : rc_m[i > 0 ? i - 1 : 0];
         checks++;
         if (bus.round_key !== rk_m[i] || bus.round_idx !== 4'(i) || bus.rcon !== exp_rc ||
             bus.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL walk[%0d]: key=%h idx=%0d rcon=%h rdy=%b, want key=%h rcon=%h",
                     i, bus.round_key, bus.round_idx, bus.rcon, bus.key_ready, rk_m[i], exp_rc);
         end
         if (fips && i == 9) begin
            checks++;
            if (bus.round_key !== 128'hac7766f319fadc2128d12941575c006e || bus.rcon !== 8'h1b) begin
               errors++;
               $display("FAIL fips_round9: got %h rcon=%h", bus.round_key, bus.rcon);
            end
         end
      end
      tick();
      checks++;
      if (bus.round_key !== key || bus.round_idx !== 4'd0 || bus.rcon !== 8'h8d ||
          bus.key_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_at_zero: key=%h idx=%0d rcon=%h rdy=%b, want key=%h idx=0 rcon=8d",
                  bus.round_key, bus.round_idx, bus.rcon, bus.key_ready, key);
      end
      bus.next = 1'b0;
   endtask

   task automatic test_restart();
      logic [127:0] key_a, key_b;
      key_a = {$urandom, $urandom, $urandom, $urandom};
      key_b = {$urandom, $urandom, $urandom, $urandom};
      bus.key_in = key_a;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int n = 0; n < 5; n++) tick();
      checks++;
      if (bus.round_idx !== 4'd5 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_pre: idx=%0d busy=%b, want idx=5 busy=1",
                  bus.round_idx, bus.busy);
      end
      build_sched(key_b);
      bus.key_in = key_b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.round_key !== key_b || bus.round_idx !== 4'd0 || bus.rcon !== 8'h01) begin
         errors++;
         $display("FAIL restart_load: key=%h idx=%0d rcon=%h, want key=%h idx=0 rcon=01",
                  bus.round_key, bus.round_idx, bus.rcon, key_b);
      end
      for (int n = 0; n < 9; n++) tick();
      checks++;
      if (bus.key_ready !== 1'b0 || bus.round_idx !== 4'd9) begin
         errors++;
         $display("FAIL restart_early: rdy=%b idx=%0d, want rdy=0 idx=9",
                  bus.key_ready, bus.round_idx);
      end
      tick();
      checks++;
      if (bus.key_ready !== 1'b1 || bus.round_key !== rk_m[10]) begin
         errors++;
         $display("FAIL restart_done: rdy=%b key=%h, want rdy=1 key=%h",
                  bus.key_ready, bus.round_key, rk_m[10]);
      end
   endtask

   task automatic test_priority();
      logic [127:0] key_c;
      key_c = {$urandom, $urandom, $urandom, $urandom};
      bus.key_in = key_c;
      bus.start = 1'b1;
      bus.next = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.next = 1'b0;
      checks++;
      if (bus.round_key !== key_c || bus.round_idx !== 4'd0 || bus.busy !== 1'b1 ||
          bus.key_ready !== 1'b0) begin
         errors++;
         $display("FAIL priority: key=%h idx=%0d busy=%b rdy=%b, want key=%h idx=0 busy=1 rdy=0",
                  bus.round_key, bus.round_idx, bus.busy, bus.key_ready, key_c);
      end
   endtask

   task automatic test_reset_mid();
      for (int n = 0; n < 3; n++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus.round_key !== '0 || bus.round_idx !== 4'd0 || bus.rcon !== 8'h00 ||
          bus.busy !== 1'b0 || bus.key_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: key=%h idx=%0d rcon=%h busy=%b rdy=%b, want all zero",
                  bus.round_key, bus.round_idx, bus.rcon, bus.busy, bus.key_ready);
      end
   endtask

   task automatic test_mix();
      logic [127:0] s, want;
      bus.mix_in = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      #1;
      checks++;
      if (bus.mix_out !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
         errors++;
         $display("FAIL mix_vector: got %h", bus.mix_out);
      end
      for (int k = 0; k < 20; k++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         want = mix_model(s);
         bus.mix_in = s;
         #1;
         checks++;
         if (bus.mix_out !== want) begin
            errors++;
            $display("FAIL mix_random: in=%h got %h want %h", s, bus.mix_out, want);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      build_sbox();
      test_reset();
      test_expand_walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
      for (int k = 0; k < 3; k++)
         test_expand_walk({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      test_restart();
      test_priority();
      test_reset_mid();
      test_mix();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
